// File: rtl/store_aligner.sv
// Store aligner: shifts register data into word-aligned write beats with byte enables; a store that crosses a word boundary becomes two beats.
// The first beat is issued the cycle after accept, and beats hold while MemReady is low. Optional MISALIGNED_STORE_TRAP_EN turns crossing stores into a one-cycle StoreFault pulse.
module store_aligner #(
  parameter int BIT_COUNT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   StoreValid,
  output logic                   StoreReady,
  input  logic [BIT_COUNT-1:0]   StoreAddr,
  input  logic [BIT_COUNT-1:0]   StoreData,
  input  logic [1:0]             StoreSize,
  output logic                   MemValid,
  input  logic                   MemReady,
  output logic [BIT_COUNT-1:0]   MemAddr,
  output logic [BIT_COUNT-1:0]   MemWriteData,
  output logic [BIT_COUNT/8-1:0] MemByteEn,
  output logic                   Busy,
  output logic                   StoreFault
);
  localparam int BYTES = BIT_COUNT / 8;
  localparam int OFS   = $clog2(BYTES);

`ifdef MISALIGNED_STORE_TRAP_EN
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
`endif

  state_t                 state;
  logic [1:0]             eff_size;
  int                     nb;
  logic [BYTES-1:0]       size_mask;
  logic [BIT_COUNT-1:0]   data_mask;
  logic [OFS-1:0]         off;
  logic [2*BYTES-1:0]     wide_mask;
  logic [2*BIT_COUNT-1:0] wide_data;
  logic [BYTES-1:0]       mask_hi;
  logic [BIT_COUNT-1:0]   data_hi;

  // A doubleword request on a 32-bit datapath is narrowed to a word.
  always_comb begin
    eff_size  = StoreSize;
    size_mask = '0;
    data_mask = '0;
    if (BIT_COUNT == 32 && StoreSize == 2'b11) eff_size = 2'b10;
    nb = 1 << eff_size;
    for (int i = 0; i < BYTES; i++) begin
      size_mask[i]          = (i < nb);
      data_mask[8*i +: 8]   = {8{size_mask[i]}};
    end
    off       = StoreAddr[OFS-1:0];
    wide_mask = {{BYTES{1'b0}}, size_mask} << off;
    wide_data = {{BIT_COUNT{1'b0}}, StoreData & data_mask} << {off, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      StoreReady   <= 1'b1;
      MemValid     <= 1'b0;
      MemAddr      <= '0;
      MemWriteData <= '0;
      MemByteEn    <= '0;
      Busy         <= 1'b0;
      mask_hi      <= '0;
      data_hi      <= '0;
`ifdef MISALIGNED_STORE_TRAP_EN
      StoreFault   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (StoreValid) begin
            StoreReady <= 1'b0;
            Busy       <= 1'b1;
`ifdef MISALIGNED_STORE_TRAP_EN
            if (|wide_mask[2*BYTES-1:BYTES]) begin
              state      <= FAULT;
              StoreFault <= 1'b1;
            end else
`endif
            begin
              state        <= BEAT0;
              MemValid     <= 1'b1;
              MemAddr      <= {StoreAddr[BIT_COUNT-1:OFS], {OFS{1'b0}}};
              MemByteEn    <= wide_mask[BYTES-1:0];
              MemWriteData <= wide_data[BIT_COUNT-1:0];
              mask_hi      <= wide_mask[2*BYTES-1:BYTES];
              data_hi      <= wide_data[2*BIT_COUNT-1:BIT_COUNT];
            end
          end
        end
        BEAT0: begin
          if (MemReady) begin
            if (|mask_hi) begin
              state        <= BEAT1;
              MemAddr      <= MemAddr + BIT_COUNT'(BYTES);
              MemByteEn    <= mask_hi;
              MemWriteData <= data_hi;
            end else begin
              state      <= IDLE;
              MemValid   <= 1'b0;
              StoreReady <= 1'b1;
              Busy       <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (MemReady) begin
            state      <= IDLE;
            MemValid   <= 1'b0;
            StoreReady <= 1'b1;
            Busy       <= 1'b0;
          end
        end
`ifdef MISALIGNED_STORE_TRAP_EN
        FAULT: begin
          state      <= IDLE;
          StoreFault <= 1'b0;
          StoreReady <= 1'b1;
          Busy       <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MISALIGNED_STORE_TRAP_EN
  assign StoreFault = 1'b0;
`endif

endmodule

// File: tb/tb_store_aligner.sv
// Directed bench for store_aligner at BIT_COUNT=32; the crossing-store step follows MISALIGNED_STORE_TRAP_EN.
module tb_store_aligner;
  logic        clk = 1'b0;
  logic        reset;
  logic        StoreValid;
  logic        StoreReady;
  logic [31:0] StoreAddr;
  logic [31:0] StoreData;
  logic [1:0]  StoreSize;
  logic        MemValid;
  logic        MemReady;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic [3:0]  MemByteEn;
  logic        Busy;
  logic        StoreFault;

  int checks   = 0;
  int failures = 0;

  store_aligner #(.BIT_COUNT(32)) dut (
    .clk(clk), .reset(reset),
    .StoreValid(StoreValid), .StoreReady(StoreReady),
    .StoreAddr(StoreAddr), .StoreData(StoreData), .StoreSize(StoreSize),
    .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr),
    .MemWriteData(MemWriteData), .MemByteEn(MemByteEn),
    .Busy(Busy), .StoreFault(StoreFault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    chk({tag, "_valid"}, 64'(MemValid), 64'd1);
    chk({tag, "_addr"}, 64'(MemAddr), 64'(a));
    chk({tag, "_be"}, 64'(MemByteEn), 64'(be));
    chk({tag, "_data"}, 64'(MemWriteData), 64'(d));
    chk({tag, "_rdy"}, 64'(StoreReady), 64'd0);
    chk({tag, "_busy"}, 64'(Busy), 64'd1);
    chk({tag, "_fault"}, 64'(StoreFault), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(MemValid), 64'd0);
    chk({tag, "_rdy"}, 64'(StoreReady), 64'd1);
    chk({tag, "_busy"}, 64'(Busy), 64'd0);
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    StoreValid = 1'b1;
    StoreAddr  = a;
    StoreData  = d;
    StoreSize  = s;
    step();
    StoreValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; StoreValid = 1'b0; StoreAddr = '0; StoreData = '0;
    StoreSize = 2'b00; MemReady = 1'b1;
    step(); step();
    chk_idle("reset");
    chk("reset_addr", 64'(MemAddr), 64'd0);
    chk("reset_be", 64'(MemByteEn), 64'd0);
    chk("reset_data", 64'(MemWriteData), 64'd0);
    chk("reset_fault", 64'(StoreFault), 64'd0);
    reset = 1'b0;
    step();

    // Byte store into the top lane; upper data bits must be dropped.
    request(32'h0000_1003, 32'hFFFF_FFAB, 2'b00);
    chk_beat("byte", 32'h0000_1000, 4'b1000, 32'hAB00_0000);
    step();
    chk_idle("byte_done");

    request(32'h0000_1002, 32'h0000_1234, 2'b01);
    chk_beat("half", 32'h0000_1000, 4'b1100, 32'h1234_0000);
    step();
    chk_idle("half_done");

    // Size 11 on a 32-bit datapath behaves as a word.
    request(32'h0000_2000, 32'h5566_7788, 2'b11);
    chk_beat("dbl_as_word", 32'h0000_2000, 4'b1111, 32'h5566_7788);
    step();
    chk_idle("dbl_done");

    request(32'h0000_1003, 32'hDDCC_BBAA, 2'b10);
`ifdef MISALIGNED_STORE_TRAP_EN
    chk("trap_valid", 64'(MemValid), 64'd0);
    chk("trap_fault", 64'(StoreFault), 64'd1);
    chk("trap_busy", 64'(Busy), 64'd1);
    step();
    chk("trap_fault_clear", 64'(StoreFault), 64'd0);
    chk_idle("trap_done");
`else
    chk_beat("cross_b0", 32'h0000_1000, 4'b1000, 32'hAA00_0000);
    step();
    chk_beat("cross_b1", 32'h0000_1004, 4'b0111, 32'h00DD_CCBB);
    step();
    chk_idle("cross_done");
    chk("cross_fault", 64'(StoreFault), 64'd0);
`endif

    request(32'h0000_1004, 32'hCAFE_F00D, 2'b10);
    chk_beat("aligned", 32'h0000_1004, 4'b1111, 32'hCAFE_F00D);
    step();
    chk_idle("aligned_done");

`ifndef MISALIGNED_STORE_TRAP_EN
    // Stalled crossing store at the top of memory; a stray request while busy must be ignored.
    MemReady = 1'b0;
    request(32'hFFFF_FFFE, 32'h1122_3344, 2'b10);
    StoreValid = 1'b1; StoreAddr = 32'h0000_3000; StoreData = 32'h9999_9999;
    for (int k = 0; k < 3; k++) begin
      chk_beat("stall_b0", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
      step();
    end
    MemReady = 1'b1;
    chk_beat("stall_b0_go", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
    step();
    MemReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_beat("stall_b1", 32'h0000_0000, 4'b0011, 32'h0000_1122);
      step();
    end
    StoreValid = 1'b0;
    MemReady = 1'b1;
    chk_beat("stall_b1_go", 32'h0000_0000, 4'b0011, 32'h0000_1122);
    step();
    chk_idle("stall_done");

    // Reset while the second beat is pending abandons it.
    request(32'h0000_1003, 32'hDDCC_BBAA, 2'b10);
    step();
    chk_beat("rst_b1", 32'h0000_1004, 4'b0111, 32'h00DD_CCBB);
    MemReady = 1'b0;
    reset = 1'b1;
    step();
    chk_idle("rst_abort");
    reset = 1'b0;
    MemReady = 1'b1;
    step();
    chk_idle("rst_no_beat");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
